// File: rtl/ahb_sram_slave_pkg.sv
// Shared AHB-Lite types for the SRAM slave: bus bundles, transfer/response
// encodings, controller states and the byte-lane strobe helper.
package ahb_sram_slave_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01
  } hresp_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } sram_state_e;

  typedef struct packed {
    logic [31:0] haddr;
    htrans_e     htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
  } mas_send_type;

  typedef struct packed {
    logic [31:0] hrdata;
    logic        hready;
    hresp_e      hresp;
  } slv_send_type;

  function automatic logic [3:0] byte_lanes(input logic [2:0] hsize, input logic [1:0] addr);
    case (hsize)
      3'd0:    return 4'b0001 << addr;
      3'd1:    return addr[1] ? 4'b1100 : 4'b0011;
      3'd2:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/ahb_sram_slave_mem.sv
// Word-organised synchronous RAM: byte-enabled write port and a registered
// read port that returns pre-write contents on a same-edge collision.
module ahb_sram_slave_mem #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [3:0]        wstrb,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: transfer legality, wait-state/ERROR sequencing,
// byte-lane writes and read-after-write bypass in front of the RAM.
module ahb_sram_slave
  import ahb_sram_slave_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic         hclk,
  input  logic         hreset_n,
  input  logic         hsel,
  input  logic         hready_in,
  input  mas_send_type slv_in,
  output slv_send_type slv_out
);

  sram_state_e       state;
  logic [2:0]        wcnt;
  logic              pend;
  logic              hready_r;
  hresp_e            hresp_r;
  logic [ADDR_W-1:0] addr_q;
  logic              write_q;
  logic [3:0]        strb_q;
  logic [3:0]        byp_strb;
  logic [31:0]       byp_data;
  logic [31:0]       ram_rdata;
  logic [31:0]       hrdata_m;

  logic              accept;
  logic              misaligned;
  logic              illegal;
  logic [ADDR_W-1:0] word;
  logic              commit;
  logic              rd_now;
  logic              rd_late;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              unused_htrans;

  assign unused_htrans = slv_in.htrans[0];

  assign accept     = hsel & hready_in & slv_in.htrans[1];
  assign misaligned = ((slv_in.hsize == 3'd1) & slv_in.haddr[0]) |
                      ((slv_in.hsize == 3'd2) & (|slv_in.haddr[1:0]));
  assign illegal    = (slv_in.hsize > 3'd2) | misaligned | (|slv_in.haddr[31:ADDR_W+2]);
  assign word       = slv_in.haddr[ADDR_W+1:2];

  // A data phase ends on any cycle where hready is high; pending writes commit there.
  assign commit  = hready_r & pend & write_q;
  assign rd_now  = hready_r & accept & ~illegal & ~slv_in.hwrite & (WAIT_STATES == 0);
  assign rd_late = (state == ST_WAIT) & (wcnt == 3'd1) & ~write_q;
  assign rd_en   = rd_now | rd_late;
  assign rd_addr = rd_now ? word : addr_q;

  ahb_sram_slave_mem #(.ADDR_W(ADDR_W)) u_mem (
    .clk   (hclk),
    .rst_n (hreset_n),
    .we    (commit),
    .wstrb (strb_q),
    .waddr (addr_q),
    .wdata (slv_in.hwdata),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (ram_rdata)
  );

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state    <= ST_IDLE;
      wcnt     <= '0;
      pend     <= 1'b0;
      hready_r <= 1'b1;
      hresp_r  <= HRESP_OKAY;
    end else begin
      case (state)
        ST_WAIT: if (wcnt != 3'd0) begin
          wcnt <= wcnt - 3'd1;
          if (wcnt == 3'd1) hready_r <= 1'b1;
        end
        ST_ERR1: begin
          state    <= ST_ERR2;
          hready_r <= 1'b1;
        end
        default: ;
      endcase
      if (hready_r) begin
        state    <= ST_IDLE;
        pend     <= 1'b0;
        hresp_r  <= HRESP_OKAY;
        if (accept) begin
          if (illegal) begin
            state    <= ST_ERR1;
            hready_r <= 1'b0;
            hresp_r  <= HRESP_ERROR;
          end else begin
            pend <= 1'b1;
            if (WAIT_STATES > 0) begin
              state    <= ST_WAIT;
              wcnt     <= 3'(WAIT_STATES);
              hready_r <= 1'b0;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge hclk) begin
    if (hready_r & accept & ~illegal) begin
      addr_q  <= word;
      write_q <= slv_in.hwrite;
      strb_q  <= byte_lanes(slv_in.hsize, slv_in.haddr[1:0]);
    end
  end

  // Capture the lanes of a write committing on the same edge a read to that word is issued.
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      byp_strb <= '0;
      byp_data <= '0;
    end else if (rd_en) begin
      byp_strb <= (rd_now & commit & (addr_q == word)) ? strb_q : 4'b0000;
      byp_data <= slv_in.hwdata;
    end
  end

  always_comb begin
    hrdata_m = ram_rdata;
    for (int i = 0; i < 4; i++) begin
      if (byp_strb[i]) hrdata_m[8*i +: 8] = byp_data[8*i +: 8];
    end
  end

  assign slv_out.hrdata = hrdata_m;
  assign slv_out.hready = hready_r;
  assign slv_out.hresp  = hresp_r;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: one zero-wait and one three-wait instance share a
// bus driver; a queue-based monitor checks every completed data phase.
module tb_ahb_sram_slave;
  import ahb_sram_slave_pkg::*;

  logic         clk = 1'b0;
  logic         hreset_n = 1'b0;
  logic         hsel = 1'b0;
  logic         sel3 = 1'b0;
  logic         hsel0, hsel3;
  mas_send_type bus;
  slv_send_type out0, out3, mon_out;

  typedef struct {
    int          id;
    bit          chk_data;
    logic [31:0] data;
    logic [1:0]  resp;
    int          waits;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   next_id = 0;
  bit   dphase = 1'b0;
  int   waits = 0;

  always #5 clk = ~clk;

  assign hsel0   = hsel & ~sel3;
  assign hsel3   = hsel & sel3;
  assign mon_out = sel3 ? out3 : out0;

  ahb_sram_slave #(.ADDR_W(10), .WAIT_STATES(0)) dut0 (
    .hclk(clk), .hreset_n(hreset_n), .hsel(hsel0), .hready_in(out0.hready),
    .slv_in(bus), .slv_out(out0)
  );

  ahb_sram_slave #(.ADDR_W(10), .WAIT_STATES(3)) dut3 (
    .hclk(clk), .hreset_n(hreset_n), .hsel(hsel3), .hready_in(out3.hready),
    .slv_in(bus), .slv_out(out3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: follows the selected slave's data phases and scores them on completion.
  always @(negedge clk) begin
    exp_t e;
    if (!hreset_n) begin
      q.delete();
      dphase = 1'b0;
      waits  = 0;
    end else begin
      if (dphase) begin
        if (q.size() == 0) begin
          chk("scoreboard_empty", 32'd0, 32'd1);
          dphase = 1'b0;
        end else if (!mon_out.hready) begin
          waits++;
          chk($sformatf("resp_wait#%0d", q[0].id), {30'd0, mon_out.hresp}, {30'd0, q[0].resp});
        end else begin
          e = q.pop_front();
          chk($sformatf("waits#%0d", e.id), waits, e.waits);
          chk($sformatf("resp#%0d", e.id), {30'd0, mon_out.hresp}, {30'd0, e.resp});
          if (e.chk_data) chk($sformatf("rdata#%0d", e.id), mon_out.hrdata, e.data);
          dphase = 1'b0;
        end
      end
      if (hsel && mon_out.hready && bus.htrans[1]) begin
        dphase = 1'b1;
        waits  = 0;
      end
    end
  end

  task automatic xfer(input logic [31:0] addr, input bit wr, input logic [2:0] size,
                      input logic [31:0] wdata, input bit chk_data, input logic [31:0] edata,
                      input logic [1:0] eresp, input int ewaits);
    exp_t e;
    int   n;
    e.id = next_id; e.chk_data = chk_data; e.data = edata; e.resp = eresp; e.waits = ewaits;
    next_id++;
    q.push_back(e);
    hsel = 1'b1; bus.haddr = addr; bus.htrans = HTRANS_NONSEQ; bus.hwrite = wr; bus.hsize = size;
    n = 0;
    @(negedge clk);
    while (!mon_out.hready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!mon_out.hready) chk($sformatf("accept_timeout#%0d", e.id), 32'd0, 32'd1);
    @(posedge clk); #1;
    if (wr) bus.hwdata = wdata;
    hsel = 1'b0; bus.htrans = HTRANS_IDLE; bus.hwrite = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  localparam logic [1:0] OK  = 2'b00;
  localparam logic [1:0] ERR = 2'b01;

  initial begin
    int n;
    bus = '0;
    bus.htrans = HTRANS_IDLE;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hready0", {31'd0, out0.hready}, 32'd1);
    chk("rst_hresp0", {30'd0, out0.hresp}, 32'd0);
    chk("rst_hrdata0", out0.hrdata, 32'd0);
    chk("rst_hready3", {31'd0, out3.hready}, 32'd1);
    chk("rst_hresp3", {30'd0, out3.hresp}, 32'd0);
    chk("rst_hrdata3", out3.hrdata, 32'd0);
    hreset_n = 1'b1;
    idle(2);

    // Zero-wait instance
    xfer(32'h10, 1, 3'd2, 32'hDEADBEEF, 0, 32'h0, OK, 0);
    xfer(32'h10, 0, 3'd2, 32'h0, 1, 32'hDEADBEEF, OK, 0);
    idle(2);
    xfer(32'h10, 1, 3'd2, 32'h11223344, 0, 32'h0, OK, 0);
    xfer(32'h13, 1, 3'd0, 32'hAB000000, 0, 32'h0, OK, 0);
    xfer(32'h10, 0, 3'd2, 32'h0, 1, 32'hAB223344, OK, 0);
    idle(3);
    xfer(32'h10, 0, 3'd2, 32'h0, 1, 32'hAB223344, OK, 0);
    xfer(32'h14, 1, 3'd2, 32'h01020304, 0, 32'h0, OK, 0);
    xfer(32'h16, 1, 3'd1, 32'hCAFE0000, 0, 32'h0, OK, 0);
    idle(1);
    xfer(32'h14, 0, 3'd2, 32'h0, 1, 32'hCAFE0304, OK, 0);
    xfer(32'h00, 1, 3'd2, 32'h0BADF00D, 0, 32'h0, OK, 0);
    xfer(32'h01, 1, 3'd1, 32'h12345678, 0, 32'h0, ERR, 1);
    xfer(32'h00, 0, 3'd2, 32'h0, 1, 32'h0BADF00D, OK, 0);
    xfer(32'h1000, 0, 3'd2, 32'h0, 1, 32'h0BADF00D, ERR, 1);
    xfer(32'h00, 0, 3'd2, 32'h0, 1, 32'h0BADF00D, OK, 0);
    xfer(32'h08, 0, 3'd3, 32'h0, 0, 32'h0, ERR, 1);
    idle(4);

    // Three-wait instance
    sel3 = 1'b1;
    idle(1);
    xfer(32'h20, 1, 3'd2, 32'h55AA55AA, 0, 32'h0, OK, 3);
    xfer(32'h20, 0, 3'd2, 32'h0, 1, 32'h55AA55AA, OK, 3);
    xfer(32'h1000, 0, 3'd2, 32'h0, 1, 32'h55AA55AA, ERR, 1);
    xfer(32'h20, 0, 3'd2, 32'h0, 1, 32'h55AA55AA, OK, 3);
    idle(6);
    xfer(32'h20, 1, 3'd2, 32'hFFFFFFFF, 0, 32'h0, OK, 3);
    @(negedge clk);
    @(negedge clk);
    #2 hreset_n = 1'b0;
    #1;
    chk("midrst_hready", {31'd0, out3.hready}, 32'd1);
    chk("midrst_hresp", {30'd0, out3.hresp}, 32'd0);
    chk("midrst_hrdata", out3.hrdata, 32'd0);
    repeat (2) @(posedge clk);
    #1 hreset_n = 1'b1;
    idle(1);
    xfer(32'h20, 0, 3'd2, 32'h0, 1, 32'h55AA55AA, OK, 3);
    idle(2);

    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
